imem_program_loader: RTL
========================

// Module: imem_program_loader
// PURPOSE
//  Writer side of the instruction-memory interface.
//  - Receives a byte-serial program image over a valid/ready stream.
//  - Assembles the bytes into 32-bit words and writes them into instruction memory at byte addresses BASE_ADDR, +4, +8, ...
//  - Holds the pipeline in reset (cpu_hold) until a load completes successfully.
//  - Sits between the host/testbench byte source and the instruction memory write port, alongside the ARM pipeline top.
// PARAMETERS
//  ADDR_W     8   instruction memory byte-address width
//  MAX_WORDS  64  largest accepted word count; must be <= 2^ADDR_W/4
//  BASE_ADDR  0   byte address of the first written word; must be 4-aligned
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-low reset
//  start         in   1       one-cycle pulse; begins a load (honoured only in IDLE/DONE/ERR)
//  in_data       in   8       stream byte
//  in_valid      in   1       in_data valid
//  in_ready      out  1       loader accepts byte; transfer occurs when in_valid && in_ready
//  mem_we        out  1       instruction memory write strobe, one cycle per word
//  mem_addr      out  ADDR_W  write byte address, 4-aligned
//  mem_wdata     out  32      write word
//  cpu_hold      out  1       1 = keep pipeline in reset
//  load_done     out  1       level; last load succeeded
//  load_err      out  1       level; last load failed
//  words_loaded  out  7       words written in current/last load
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE, cpu_hold=1, all other outputs 0. Reset mid-load aborts the load with no further writes.
//  States: IDLE, HDR, DATA, WRITE, CHK (macro only), DONE, ERR.
//  - IDLE: in_ready=0, cpu_hold=1. start -> HDR. Clears words_loaded, byte index and flags.
//  - HDR: in_ready=1. Accepted byte N is the word count.
//      N==0 or N>MAX_WORDS -> ERR.
//      Otherwise latch N, set addr=BASE_ADDR, go to DATA.
//  - DATA: in_ready=1. Bytes are big-endian per word: 1st byte -> [31:24] ... 4th byte -> [7:0].
//      The 2-bit byte index wraps 3->0. The 4th accepted byte -> WRITE.
//  - WRITE: exactly one cycle.
//      in_ready=0, mem_we=1, mem_addr=addr, mem_wdata=assembled word.
//      Next edge: addr+=4 (mod 2^ADDR_W), words_loaded+=1.
//      If words_loaded+1==N -> CHK (macro) or DONE; else -> DATA.
//  - DONE: cpu_hold=0, load_done=1, in_ready=0.
//  - ERR: cpu_hold=1, load_err=1, in_ready=0.
//  - start in DONE/ERR -> HDR with cpu_hold=1, load_done/load_err cleared, words_loaded=0. start in HDR/DATA/WRITE/CHK is ignored.
//  - in_valid with in_ready=0 is not consumed; the source holds the byte. Gaps in in_valid are allowed anywhere.
//  - Latency: the word write occurs in the cycle after its 4th byte is accepted. Max throughput is 4 bytes per 5 cycles.
//  - mem_addr/mem_wdata hold their last values when mem_we=0.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    - The stream carries one extra trailing byte.
//    - Running XOR of the header byte and all payload bytes is kept.
//    - CHK: in_ready=1; accepted byte == XOR -> DONE, else -> ERR. Words already written stay written.
//  Not defined: no CHK state; after the last WRITE -> DONE.
// STRUCTURE
//  Package imem_loader_pkg:
//    - state enum (IDLE, HDR, DATA, WRITE, CHK, DONE, ERR);
//    - WORD_W=32 and BYTE_W=8 constants.
//  One sub-module: loader_word_packer. Holds the byte index, shift register and word_ready pulse. The FSM stays in the top.
// TESTING
//  1. Stream 02, DE AD BE EF, 11 22 33 44.
//     -> writes 0xDEADBEEF@0x00 and 0x11223344@0x04; words_loaded=2; load_done=1; cpu_hold=0.
//  2. Header 00, then header 41 (65) -> load_err=1, cpu_hold=1, no mem_we.
//  3. Count 01 with in_valid toggling every other cycle -> single write 0x0A0B0C0D@0x00; in_ready=0 during WRITE.
//  4. Assert reset after 2 payload bytes of a 3-word load -> no mem_we afterwards; all outputs at reset values; cpu_hold=1.
//  5. LOADER_CHECKSUM_EN: 01 12 34 56 78 + checksum 0x09 -> DONE. Same stream with 0x00 -> ERR after the write.
//  6. start pulse during DATA -> ignored. After DONE, start plus a new image -> words_loaded restarts at 0, writes begin at BASE_ADDR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and width constants for the instruction-memory program loader.
package imem_loader_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_e;
endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_program_loader_if #(
  parameter int ADDR_W = 8
);
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (input in_data, in_valid, output in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (output in_data, in_valid, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/loader_word_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_ready flags the 4th byte of each word.
module loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);
  logic [1:0]               idx;
  logic [WORD_W-BYTE_W-1:0] sh;

  assign word_ready = byte_en && (idx == 2'd3);

  // word only changes on a completed word, so it doubles as the held write data
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx  <= 2'd0;
      sh   <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= 2'd0;
    end else if (byte_en) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) word <= {sh, byte_in};
      else             sh   <= {sh[WORD_W-2*BYTE_W-1:0], byte_in};
    end
  end
endmodule

// File: rtl/imem_program_loader.sv
// Loads a byte-serial program image into instruction memory and holds the CPU until it succeeds.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  imem_program_loader_if.master bus,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_err,
  output logic [6:0]           words_loaded
);
  localparam logic [BYTE_W-1:0] MAX_N = BYTE_W'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  loader_state_e     state, state_n;
  logic [6:0]        n_words;
  logic [ADDR_W-1:0] addr, mem_addr_q;
  logic              in_ready_c, mem_we_c, accept, start_ok, word_ready;
  logic [WORD_W-1:0] word;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  assign accept   = bus.in_valid && in_ready_c;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERR);

  loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (accept && (state == DATA)),
    .byte_in    (bus.in_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    in_ready_c = 1'b0;
    mem_we_c   = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      IDLE: if (start) state_n = HDR;
      HDR: begin
        in_ready_c = 1'b1;
        if (bus.in_valid)
          state_n = (bus.in_data == '0 || bus.in_data > MAX_N) ? ERR : DATA;
      end
      DATA: begin
        in_ready_c = 1'b1;
        if (word_ready) state_n = WRITE;
      end
      WRITE: begin
        mem_we_c = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_n = (words_loaded + 7'd1 == n_words) ? CHK : DATA;
`else
        state_n = (words_loaded + 7'd1 == n_words) ? DONE : DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_n = (bus.in_data == csum) ? DONE : ERR;
      end
`endif
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (start) state_n = HDR;
      end
      ERR: begin
        load_err = 1'b1;
        if (start) state_n = HDR;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control and visible outputs: cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      words_loaded <= '0;
      mem_addr_q   <= '0;
    end else begin
      if (start_ok)        words_loaded <= '0;
      if (word_ready)      mem_addr_q   <= addr;
      if (state == WRITE)  words_loaded <= words_loaded + 7'd1;
    end
  end

  // Load bookkeeping: always initialised in HDR before use
  always_ff @(posedge clk) begin
    if (state == HDR && accept) begin
      n_words <= bus.in_data[6:0];
      addr    <= BASE;
    end
    if (state == WRITE) addr <= addr + ADDR_W'(4);
`ifdef LOADER_CHECKSUM_EN
    if (state == HDR && accept)  csum <= bus.in_data;
    if (state == DATA && accept) csum <= csum ^ bus.in_data;
`endif
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = word;
endmodule
